// File: rtl/sr_drive_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// sr_drv_pkg
// Shared types and constants for the SR latch drive sequencer.
//   sr_drv_state_t : sequencer state encoding (IDLE, PULSE, GAP)
//   SR_CMD_SET     : req_set value that drives the latch 's' input
//   SR_CMD_RESET   : req_set value that drives the latch 'r' input
// -----------------------------------------------------------------------------
package sr_drv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } sr_drv_state_t;

    localparam logic SR_CMD_SET   = 1'b1;
    localparam logic SR_CMD_RESET = 1'b0;

endpackage

// File: rtl/sr_drive_sequencer_if.sv
// -----------------------------------------------------------------------------
// sr_drive_sequencer_if
// Command handshake between a requester and the SR drive sequencer.
//   req_valid : a command is offered        (master -> slave)
//   req_set   : 1 = set command, 0 = reset  (master -> slave)
//   req_ready : sequencer can take a command (slave -> master)
// A command transfers on a rising edge where req_valid && req_ready.
// -----------------------------------------------------------------------------
interface sr_drive_sequencer_if;

    logic req_valid;
    logic req_set;
    logic req_ready;

    modport master (
        output req_valid,
        output req_set,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_set,
        output req_ready
    );

endinterface

// File: rtl/sr_drive_sequencer_timer.sv
// -----------------------------------------------------------------------------
// sr_drv_timer
// Loadable down-counter used to time the PULSE and GAP phases.
//   clk    : rising-edge clock
//   rst    : synchronous active-high reset, clears the count
//   load   : load 'value' on the next edge (has priority over counting)
//   value  : count to load
//   enable : decrement on the next edge; holds at zero
//   zero   : count is currently zero
// -----------------------------------------------------------------------------
module sr_drv_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] value,
    input  logic             enable,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    // NOTE: state is updated with non-blocking assignments so every register
    // sees the pre-edge values of the others, independent of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (enable && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/sr_drive_sequencer.sv
// -----------------------------------------------------------------------------
// sr_drive_sequencer
// Turns set/reset commands into a fixed-width pulse on the SR latch 's' or 'r'
// input followed by a guard gap; 's' and 'r' are never high together.
//
// Parameters:
//   PULSE_W : cycles s/r is held high per command (>= 1)
//   GAP_W   : cycles both outputs stay low after the pulse (>= 0)
//   CNT_W   : timer width, 2**CNT_W > max(PULSE_W, GAP_W)
//
// Ports:
//   clk   : rising-edge clock
//   rst   : synchronous active-high reset
//   req   : command handshake (slave side of sr_drive_sequencer_if)
//   s, r  : registered latch drives
//   busy  : a command is in progress
//   done  : one-cycle pulse in the first IDLE cycle after a command
//   q     : latch output readback      (SR_DRV_READBACK_EN only)
//   err   : sticky readback mismatch   (SR_DRV_READBACK_EN only)
//
// Build option: define SR_DRV_READBACK_EN to add the q/err readback check.
// -----------------------------------------------------------------------------
module sr_drive_sequencer
    import sr_drv_pkg::*;
#(
    parameter int PULSE_W = 4,
    parameter int GAP_W   = 2,
    parameter int CNT_W   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    sr_drive_sequencer_if.slave  req,
    output logic                 s,
    output logic                 r,
    output logic                 busy,
    output logic                 done
`ifdef SR_DRV_READBACK_EN
    ,
    input  logic                 q,
    output logic                 err
`endif
);

    // Legacy-style state constants, tied to the package encoding.
    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_PULSE = PULSE;
    localparam logic [1:0] ST_GAP   = GAP;

    localparam bit               HAS_GAP    = (GAP_W > 0);
    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_W - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD   = HAS_GAP ? CNT_W'(GAP_W - 1) : '0;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic             cmd_q;
    logic             cmd_nxt;
    logic             accept;
    logic             timer_load;
    logic [CNT_W-1:0] timer_value;
    logic             timer_zero;

    assign req.req_ready = (state == ST_IDLE);
    assign busy          = (state != ST_IDLE);
    assign accept        = req.req_valid && req.req_ready;

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_nxt   = state;
        cmd_nxt     = cmd_q;
        timer_load  = 1'b0;
        timer_value = PULSE_LOAD;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt   = ST_PULSE;
                    cmd_nxt     = req.req_set;
                    timer_load  = 1'b1;
                    timer_value = PULSE_LOAD;
                end
            end
            ST_PULSE: begin
                if (timer_zero) begin
                    if (HAS_GAP) begin
                        state_nxt   = ST_GAP;
                        timer_load  = 1'b1;
                        timer_value = GAP_LOAD;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            ST_GAP: begin
                if (timer_zero) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    sr_drv_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (timer_load),
        .value  (timer_value),
        .enable (busy),
        .zero   (timer_zero)
    );

    // s/r are registered from the next state and the next command bit, so they
    // change only on the clock edge and are mutually exclusive by construction.
    // NOTE: reset lives inside the clocked block (synchronous); every control
    // register here is reset, there is no storage array that could skip it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cmd_q <= SR_CMD_RESET;
            s     <= 1'b0;
            r     <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            cmd_q <= cmd_nxt;
            s     <= (state_nxt == ST_PULSE) && (cmd_nxt == SR_CMD_SET);
            r     <= (state_nxt == ST_PULSE) && (cmd_nxt == SR_CMD_RESET);
            done  <= (state != ST_IDLE) && (state_nxt == ST_IDLE);
        end
    end

`ifdef SR_DRV_READBACK_EN
    // The latch has seen the whole pulse by the edge that leaves PULSE, so q
    // must match the commanded value there; a mismatch sticks until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if ((state == ST_PULSE) && timer_zero && (q != cmd_q)) begin
            err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_sr_drive_sequencer.sv
// -----------------------------------------------------------------------------
// tb_sr_drive_sequencer
// Self-checking bench for sr_drive_sequencer. A default instance (PULSE_W=4,
// GAP_W=2) is driven through directed steps; every accepted command is pushed
// to a scoreboard and popped by a monitor when 'done' appears, which checks the
// pulsed line, pulse start, pulse width and done latency. A second instance
// (PULSE_W=1, GAP_W=0) covers the minimum-length command.
// Define SR_DRV_READBACK_EN to also exercise the readback/err path.
// -----------------------------------------------------------------------------
module tb_sr_drive_sequencer;

    localparam int P = 4;
    localparam int G = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sr_drive_sequencer_if req_if ();
    sr_drive_sequencer_if req2_if ();

    logic s, r, busy, done;
    logic s2, r2, busy2, done2;

`ifdef SR_DRV_READBACK_EN
    logic q_lat  = 1'b0;
    logic q_lat2 = 1'b0;
    logic err, err2;
    logic stuck  = 1'b0;
`endif

    sr_drive_sequencer #(
        .PULSE_W (P),
        .GAP_W   (G),
        .CNT_W   (4)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req_if),
        .s    (s),
        .r    (r),
        .busy (busy),
        .done (done)
`ifdef SR_DRV_READBACK_EN
        ,
        .q    (q_lat),
        .err  (err)
`endif
    );

    sr_drive_sequencer #(
        .PULSE_W (1),
        .GAP_W   (0),
        .CNT_W   (2)
    ) dut2 (
        .clk  (clk),
        .rst  (rst),
        .req  (req2_if),
        .s    (s2),
        .r    (r2),
        .busy (busy2),
        .done (done2)
`ifdef SR_DRV_READBACK_EN
        ,
        .q    (q_lat2),
        .err  (err2)
`endif
    );

`ifdef SR_DRV_READBACK_EN
    // Behavioural SR latch; 'stuck' models a latch that will not set.
    always @(posedge clk) begin
        if (rst || stuck) q_lat <= 1'b0;
        else if (s)       q_lat <= 1'b1;
        else if (r)       q_lat <= 1'b0;
    end
    always @(posedge clk) begin
        if (rst)     q_lat2 <= 1'b0;
        else if (s2) q_lat2 <= 1'b1;
        else if (r2) q_lat2 <= 1'b0;
    end
`endif

    int cyc      = 0;
    int n_checks = 0;
    int n_err    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------ scoreboard
    typedef struct packed {
        logic is_set;
        int   acc;      // edge on which the command is accepted
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   plen   = 0;
    int   pstart = 0;
    logic pset   = 1'b0;

    always @(negedge clk) begin
        check("s_and_r_exclusive", s && r, 1'b0);
        check("s2_and_r2_exclusive", s2 && r2, 1'b0);
        if (rst) begin
            plen = 0;
        end else begin
            if (s || r) begin
                if (plen == 0) begin
                    pstart = cyc;
                    pset   = s;
                end
                plen++;
            end
            if (done) begin
                check("sb_nonempty_at_done", sb.size() > 0, 1'b1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("sb_pulse_line", pset, e.is_set);
                    check("sb_pulse_start", pstart - e.acc, 0);
                    check("sb_pulse_width", plen, P);
                    check("sb_done_latency", cyc - e.acc, P + G);
                end
                plen = 0;
            end
        end
    end

    // ------------------------------------------------------------ stimulus
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Issue one command from IDLE and follow it to its done cycle.
    task automatic run_cmd(input logic set);
        req_if.req_valid = 1'b1;
        req_if.req_set   = set;
        sb.push_back('{is_set: set, acc: cyc + 1});
        tick();
        req_if.req_valid = 1'b0;
        for (int k = 0; k < P; k++) begin
            check("pulse_s", s, set);
            check("pulse_r", r, !set);
            check("pulse_ready_low", req_if.req_ready, 1'b0);
            tick();
        end
        for (int k = 0; k < G; k++) begin
            check("gap_s", s, 1'b0);
            check("gap_r", r, 1'b0);
            check("gap_busy", busy, 1'b1);
            tick();
        end
        check("done_flag", done, 1'b1);
        check("done_ready", req_if.req_ready, 1'b1);
    endtask

    initial begin
        req_if.req_valid  = 1'b0;
        req_if.req_set    = 1'b0;
        req2_if.req_valid = 1'b0;
        req2_if.req_set   = 1'b0;

        // Reset state
        rst = 1'b1;
        tick(3);
        check("rst_s", s, 1'b0);
        check("rst_r", r, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_ready", req_if.req_ready, 1'b1);
`ifdef SR_DRV_READBACK_EN
        check("rst_err", err, 1'b0);
`endif
        rst = 1'b0;
        tick(2);

        // Set command, then single-cycle done
        run_cmd(1'b1);
        tick();
        check("done_one_cycle", done, 1'b0);
        check("idle_busy", busy, 1'b0);

        // Reset command
        run_cmd(1'b0);
        tick();

        // Continuous valid with req_set toggling every cycle: only the value
        // present on each 7th edge is taken, the rest is ignored.
        req_if.req_valid = 1'b1;
        req_if.req_set   = 1'b1;
        for (int i = 0; i < 4 * (P + G + 1); i++) begin
            if (i % (P + G + 1) == 0)
                sb.push_back('{is_set: req_if.req_set, acc: cyc + 1});
            tick();
            check("stream_ready", req_if.req_ready, (i % (P + G + 1)) == (P + G));
            req_if.req_set = ~req_if.req_set;
        end
        req_if.req_valid = 1'b0;
        tick();
        check("stream_idle_busy", busy, 1'b0);

        // Reset in the 2nd PULSE cycle, together with a new request
        req_if.req_valid = 1'b1;
        req_if.req_set   = 1'b1;
        tick();
        req_if.req_valid = 1'b0;
        check("abort_pulse1_s", s, 1'b1);
        tick();
        check("abort_pulse2_s", s, 1'b1);
        rst              = 1'b1;
        req_if.req_valid = 1'b1;
        req_if.req_set   = 1'b0;
        tick();
        check("abort_s", s, 1'b0);
        check("abort_r", r, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_ready", req_if.req_ready, 1'b1);
        rst              = 1'b0;
        req_if.req_valid = 1'b0;
        for (int k = 0; k < P + G + 2; k++) begin
            tick();
            check("abort_no_done", done, 1'b0);
        end
        run_cmd(1'b1);
        tick();

        // Minimum command: PULSE_W=1, GAP_W=0, back-to-back period of 2
        req2_if.req_valid = 1'b1;
        req2_if.req_set   = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("min_pulse_s", s2, 1'b1);
            check("min_pulse_done", done2, 1'b0);
            check("min_pulse_busy", busy2, 1'b1);
            tick();
            check("min_done_s", s2, 1'b0);
            check("min_done", done2, 1'b1);
            check("min_done_ready", req2_if.req_ready, 1'b1);
        end
        req2_if.req_valid = 1'b0;
        tick();
        check("min_idle_s", s2, 1'b0);
        check("min_idle_done", done2, 1'b0);
        check("min_r2_low", r2, 1'b0);

        // Mixed back-to-back and spaced commands
        for (int i = 0; i < 12; i++) begin
            run_cmd(1'($urandom_range(0, 1)));
            tick($urandom_range(0, 2));
        end
        tick();

`ifdef SR_DRV_READBACK_EN
        check("rb_err_clean", err, 1'b0);

        // Latch refuses to set: err rises on the PULSE exit edge and sticks.
        stuck            = 1'b1;
        req_if.req_valid = 1'b1;
        req_if.req_set   = 1'b1;
        sb.push_back('{is_set: 1'b1, acc: cyc + 1});
        tick();
        req_if.req_valid = 1'b0;
        tick(P - 1);
        check("rb_err_before_exit", err, 1'b0);
        tick();
        check("rb_err_after_exit", err, 1'b1);
        stuck = 1'b0;
        tick(G);
        run_cmd(1'b0);
        check("rb_err_sticky1", err, 1'b1);
        run_cmd(1'b1);
        check("rb_err_sticky2", err, 1'b1);
        rst = 1'b1;
        tick();
        check("rb_err_cleared", err, 1'b0);
        rst = 1'b0;
        tick();
`endif

        tick(3);
        check("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/sr_drive_sequencer.md
# sr_drive_sequencer

Upstream command stage for the gated SR latch. Accepts set/reset requests over a valid/ready handshake and turns each one into a clean, fixed-width pulse on the latch's `s` or `r` input, followed by a guard gap. It guarantees that `s` and `r` are never high together, so the latch never sees its forbidden input. Optionally, it reads back the latch output and flags any mismatch.

## Interface
Parameters:
- `PULSE_W`, default 4: cycles `s`/`r` is held high per command; legal range ≥1.
- `GAP_W`, default 2: cycles both outputs are held low after a pulse; legal range ≥0.
- `CNT_W`, default 4: width of the internal timer; must satisfy 2^CNT_W > max(PULSE_W, GAP_W).

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `req_valid`  in  1: a command is offered.
- `req_set`  in  1: command type; 1 = set (drive `s`), 0 = reset (drive `r`).
- `req_ready`  out  1: block can accept a command.
- `s`  out  1: registered set drive to the latch.
- `r`  out  1: registered reset drive to the latch.
- `busy`  out  1: a command is in progress (state ≠ IDLE).
- `done`  out  1: one-cycle pulse when a command completes.
- `q`  in  1: latch output readback; present only with `SR_DRV_READBACK_EN`.
- `err`  out  1: sticky readback mismatch flag; present only with `SR_DRV_READBACK_EN`.

## Operation
- States:
  - IDLE: `req_ready`=1, `s`=`r`=0.
  - PULSE: exactly one of `s`/`r` high, selected by the latched `req_set`.
  - GAP: `s`=`r`=0.
- IDLE→PULSE on `req_valid && req_ready`:
  - `req_set` is latched into `cmd_q`.
  - The timer is loaded with PULSE_W-1.
- PULSE:
  - The timer counts down.
  - When it reaches 0: go to GAP with the timer loaded with GAP_W-1 if GAP_W>0; otherwise go to IDLE.
- GAP:
  - The timer counts down.
  - When it reaches 0: go to IDLE.
- `done` is asserted for the single cycle after the final PULSE or GAP cycle, i.e. the first IDLE cycle.
- `req_ready` is combinational from the state (IDLE only). `req_valid` is ignored outside IDLE; requests are not queued. Once accepted, a command cannot be cancelled except by `rst`.
- `s` and `r` are driven from registered state. `s && r` is never 1, including during reset and at state transitions.
- Back-to-back commands: a request offered in the `done` cycle is accepted in that cycle, so the next pulse starts on the following cycle.
- Commands are not filtered: a set issued while the latch is already set still produces a full pulse.

## Timing
- Reset values: state=IDLE, `s`=0, `r`=0, `busy`=0, `done`=0, `err`=0, timer=0, `cmd_q`=0.
- Accept at edge N → `s`/`r` high for cycles N+1 … N+PULSE_W.
- Gap covers cycles N+PULSE_W+1 … N+PULSE_W+GAP_W.
- `done`=1 and `req_ready`=1 in cycle N+PULSE_W+GAP_W+1.
- Command period is PULSE_W+GAP_W+1 cycles.
- `rst` asserted mid-PULSE or mid-GAP: at the next rising edge, outputs return to reset values and no `done` is produced.
- `rst` has priority over a simultaneous request.

## Configuration
- `SR_DRV_READBACK_EN` defined:
  - Ports `q` and `err` exist.
  - `q` is sampled on the edge that leaves PULSE.
  - If `q` ≠ `cmd_q`, `err` is set and stays set until `rst`.
- `SR_DRV_READBACK_EN` undefined: no `q`/`err` ports and no readback logic; all other behaviour is identical.

## Structure
- Package `sr_drv_pkg`:
  - State enum `sr_drv_state_t` {IDLE, PULSE, GAP}.
  - Constants `SR_CMD_SET`=1'b1 and `SR_CMD_RESET`=1'b0.
- Sub-module `sr_drv_timer`: CNT_W-bit loadable down-counter with inputs load/value/enable and output `zero`, instantiated once.

## Test plan
Default parameters (PULSE_W=4, GAP_W=2) unless noted.
1. Reset, then `req_valid`=1, `req_set`=1 at cycle 10 → `s`=1 on cycles 11–14, `r`=0 throughout, `done`=1 at cycle 17, `req_ready` low on cycles 11–16.
2. Reset command (`req_set`=0) → `r` high for exactly 4 cycles and `s`=0; an assertion of `s && r` never firing across the whole run.
3. `req_valid` held high continuously, alternating `req_set` → one pulse every 7 cycles; requests during PULSE/GAP ignored.
4. `rst` asserted in the 2nd PULSE cycle → `s`=0 at the next edge, no `done`; the next command starts cleanly with a full 4-cycle pulse.
5. GAP_W=0, PULSE_W=1 → `s` high 1 cycle, `done` the following cycle, period 2 cycles.
6. With `SR_DRV_READBACK_EN`: latch model forced to hold `q`=0 during a set command → `err`=1 after the PULSE exit edge and stays 1 until `rst`; with a correct latch, `err` remains 0 over 20 mixed commands.
